mem_port_arbiter: RTL and testbench

Shares a single 32-bit synchronous memory port between the instruction-fetch requester and the load/store requester of the RV32I core. Data accesses have fixed priority, with an optional starvation guard that periodically forces a fetch grant. The block sits between the core's IF/MEM stages and the unified memory model; it latches each granted request and owns the memory-side handshake until completion.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arb_starve_cnt.sv | 35 +++
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory port arbiter.
package mem_arb_pkg;

  localparam logic [1:0] OwnerNone = 2'd0;
  localparam logic [1:0] OwnerI    = 2'd1;
  localparam logic [1:0] OwnerD    = 2'd2;

  // State value doubles as the current owner of the memory port.
  typedef enum logic [1:0] {
    StIdle = OwnerNone,
    StGntI = OwnerI,
    StGntD = OwnerD
  } arb_state_e;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of data grants issued while fetch is waiting; flags when fetch must win.
module mem_arb_starve_cnt #(
  parameter int unsigned StarveMax = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic override
);

  localparam int unsigned CntW = $clog2(StarveMax + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign override = (cnt_q == CntW'(StarveMax));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !override) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between fetch and load/store; data has priority.
// Define MEM_ARB_STARVE_GUARD_EN to periodically force a fetch grant under data pressure.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic [DW-1:0]   i_rdata,
  output logic            i_ack,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic [DW-1:0]   d_rdata,
  output logic            d_ack,
  output logic            m_req,
  output logic            m_we,
  output logic [DW/8-1:0] m_be,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic [DW-1:0]   m_rdata,
  input  logic            m_ack
);

  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("STARVE_MAX must be at least 1");
  end

  arb_state_e      state_q, state_d;
  logic            m_we_q, m_we_d;
  logic [DW/8-1:0] m_be_q, m_be_d;
  logic [AW-1:0]   m_addr_q, m_addr_d;
  logic [DW-1:0]   m_wdata_q, m_wdata_d;

  logic idle, take_d, take_i, override;

  assign idle   = (state_q == StIdle);
  assign take_d = d_req & ~(override & i_req);
  assign take_i = ~take_d & i_req;

`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_starve_cnt #(
    .StarveMax(STARVE_MAX)
  ) u_starve_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (idle & take_d & i_req),
    .clr     (idle & take_i),
    .override(override)
  );
`else
  assign override = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    m_we_d    = m_we_q;
    m_be_d    = m_be_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    unique case (state_q)
      StIdle: begin
        if (take_d) begin
          state_d   = StGntD;
          m_we_d    = d_we;
          m_be_d    = d_be;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
        end else if (take_i) begin
          state_d   = StGntI;
          m_we_d    = 1'b0;
          m_be_d    = '1;
          m_addr_d  = i_addr;
          m_wdata_d = '0;
        end
      end
      StGntI, StGntD: begin
        if (m_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      m_we_q    <= 1'b0;
      m_be_q    <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      m_we_q    <= m_we_d;
      m_be_q    <= m_be_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  // Driven straight from registers so an async reset drops the request at once.
  assign m_req   = ~idle;
  assign m_we    = m_we_q;
  assign m_be    = m_be_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;

  assign i_ack   = (state_q == StGntI) & m_ack;
  assign d_ack   = (state_q == StGntD) & m_ack;
  assign i_rdata = (state_q == StGntI) ? m_rdata : '0;
  assign d_rdata = (state_q == StGntD) ? m_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random checks of mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned STARVE_MAX = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk, rst_n;
  logic          i_req, i_ack, d_req, d_we, d_ack, m_req, m_we, m_ack;
  logic [AW-1:0] i_addr, d_addr, m_addr;
  logic [DW-1:0] i_rdata, d_wdata, d_rdata, m_wdata, m_rdata;
  logic [BW-1:0] d_be, m_be;

  mem_port_arbiter #(
    .AW        (AW),
    .DW        (DW),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_req  (i_req),
    .i_addr (i_addr),
    .i_rdata(i_rdata),
    .i_ack  (i_ack),
    .d_req  (d_req),
    .d_we   (d_we),
    .d_be   (d_be),
    .d_addr (d_addr),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_ack  (d_ack),
    .m_req  (m_req),
    .m_we   (m_we),
    .m_be   (m_be),
    .m_addr (m_addr),
    .m_wdata(m_wdata),
    .m_rdata(m_rdata),
    .m_ack  (m_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who owns the port, what was granted, how long fetch has waited.
  bit            mdl_busy, mdl_own_d, i_done, d_done;
  logic          mdl_we;
  logic [BW-1:0] mdl_be;
  logic [AW-1:0] mdl_addr;
  logic [DW-1:0] mdl_wdata;
  int unsigned   mdl_starve;

  int n_assert = 0;
  int n_fail   = 0;
  int ack_log[$];
  int exp_seq[10];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mdl_busy = 0; mdl_own_d = 0; i_done = 0; d_done = 0; mdl_starve = 0;
    mdl_we = 0; mdl_be = '0; mdl_addr = '0; mdl_wdata = '0;
  endtask

  task automatic check_outputs();
    logic exp_i_ack, exp_d_ack;
    exp_i_ack = mdl_busy && !mdl_own_d && m_ack;
    exp_d_ack = mdl_busy && mdl_own_d && m_ack;
    chk("m_req", m_req, mdl_busy);
    chk("i_ack", i_ack, exp_i_ack);
    chk("d_ack", d_ack, exp_d_ack);
    if (mdl_busy) begin
      chk("m_we", m_we, mdl_we);
      chk("m_be", m_be, mdl_be);
      chk("m_addr", m_addr, mdl_addr);
      if (mdl_own_d) chk("m_wdata", m_wdata, mdl_wdata);
    end
    if (exp_i_ack) chk("i_rdata", i_rdata, m_rdata);
    if (exp_d_ack) chk("d_rdata", d_rdata, m_rdata);
    if (i_ack) ack_log.push_back(0);
    if (d_ack) ack_log.push_back(1);
  endtask

  task automatic model_edge();
    bit ovr;
    i_done = 0;
    d_done = 0;
    ovr = GUARD && (mdl_starve == STARVE_MAX);
    if (mdl_busy) begin
      if (m_ack) begin
        mdl_busy = 0;
        if (mdl_own_d) d_done = 1;
        else i_done = 1;
      end
    end else if (d_req && !(ovr && i_req)) begin
      mdl_busy = 1; mdl_own_d = 1;
      mdl_we = d_we; mdl_be = d_be; mdl_addr = d_addr; mdl_wdata = d_wdata;
      if (GUARD && i_req && mdl_starve < STARVE_MAX) mdl_starve++;
    end else if (i_req) begin
      mdl_busy = 1; mdl_own_d = 0;
      mdl_we = 0; mdl_be = '1; mdl_addr = i_addr;
      mdl_starve = 0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_random();
    if (!i_req || i_done) begin
      i_req  = ($urandom % 3) != 0;
      i_addr = AW'($urandom);
    end
    if (!d_req || d_done) begin
      d_req   = ($urandom % 3) != 0;
      d_we    = 1'($urandom % 2);
      d_be    = BW'($urandom);
      d_addr  = AW'($urandom);
      d_wdata = DW'($urandom);
    end
    m_ack   = mdl_busy ? (($urandom % 3) == 0) : (($urandom % 5) == 0);
    m_rdata = DW'($urandom);
  endtask

  initial begin
    rst_n = 0; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_be = '0;
    d_addr = '0; d_wdata = '0; m_rdata = '0; m_ack = 0;
    model_reset();
    for (int k = 0; k < 10; k++) exp_seq[k] = (GUARD && (k == 4 || k == 9)) ? 0 : 1;

    // Reset values
    #12;
    chk("rst_m_req", m_req, 0);
    chk("rst_m_we", m_we, 0);
    chk("rst_m_be", m_be, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_i_ack", i_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    rst_n = 1;
    @(posedge clk);
    #1;

    // Single fetch, zero-wait memory
    i_req = 1; i_addr = 32'h100;
    #3;
    chk("fetch_n_m_req", m_req, 0);
    cycle();
    m_ack = 1; m_rdata = 32'hDEADBEEF;
    #3;
    chk("fetch_m_req", m_req, 1);
    chk("fetch_m_addr", m_addr, 32'h100);
    chk("fetch_m_we", m_we, 0);
    chk("fetch_i_ack", i_ack, 1);
    chk("fetch_i_rdata", i_rdata, 32'hDEADBEEF);
    cycle();
    i_req = 0; m_ack = 0;
    cycle();

    // Store with three wait states
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h200; d_wdata = 32'h1234;
    cycle();
    for (int w = 0; w < 4; w++) begin
      m_ack = (w == 3);
      #3;
      chk("st_m_addr", m_addr, 32'h200);
      chk("st_m_we", m_we, 1);
      chk("st_m_be", m_be, 4'b0011);
      chk("st_m_wdata", m_wdata, 32'h1234);
      chk("st_d_ack", d_ack, (w == 3));
      chk("st_i_ack", i_ack, 0);
      cycle();
    end
    d_req = 0; d_we = 0; m_ack = 0;
    cycle();

    // Both requesters held, zero-wait memory
    i_req = 1; i_addr = 32'h300;
    d_req = 1; d_addr = 32'h400; d_be = 4'hF; d_wdata = 32'h55;
    m_ack = 1;
    ack_log.delete();
    repeat (20) cycle();
    chk("seq_len", ack_log.size(), 10);
    for (int k = 0; k < 10 && k < ack_log.size(); k++) chk("grant_seq", ack_log[k], exp_seq[k]);
    d_req = 0;
    ack_log.delete();
    repeat (2) cycle();
    chk("fetch_after_data", (ack_log.size() == 1) ? ack_log[0] : -1, 0);
    i_req = 0; m_ack = 0;
    cycle();

    // Spurious ack while idle
    m_ack = 1;
    #3;
    chk("spur_i_ack", i_ack, 0);
    chk("spur_d_ack", d_ack, 0);
    cycle();
    m_ack = 0;
    #3;
    chk("spur_m_req", m_req, 0);
    cycle();

    // Reset in the middle of a data grant
    d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h500; d_wdata = 32'hA5A5;
    cycle();
    #1;
    chk("mid_m_req_before", m_req, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_m_req", m_req, 0);
    chk("mid_rst_d_ack", d_ack, 0);
    chk("mid_rst_i_ack", i_ack, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    model_edge();
    #1;
    #3;
    chk("regrant_m_req", m_req, 1);
    chk("regrant_m_addr", m_addr, 32'h500);
    cycle();
    m_ack = 1;
    cycle();
    d_req = 0; m_ack = 0;
    cycle();

    // Random traffic with a random-latency memory
    for (int n = 0; n < 400; n++) begin
      drive_random();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
